// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// seq_alu_pkg
//   Shared definitions for the multi-cycle execute-stage ALU:
//     - EXE_* command codes (4-bit, matching the default CMD_W)
//     - FSM state enum (IDLE / MUL / DIV)
//     - cnt_width(): iteration-counter width for a given operand WIDTH
//   Optional feature macro used by the ALU files: SEQ_ALU_DIV_EN.
// -----------------------------------------------------------------------------
package seq_alu_pkg;

   localparam int CMD_W_DEF = 4;

   localparam logic [CMD_W_DEF-1:0] EXE_ADD  = 4'd0;
   localparam logic [CMD_W_DEF-1:0] EXE_SUB  = 4'd1;
   localparam logic [CMD_W_DEF-1:0] EXE_AND  = 4'd2;
   localparam logic [CMD_W_DEF-1:0] EXE_OR   = 4'd3;
   localparam logic [CMD_W_DEF-1:0] EXE_NOR  = 4'd4;
   localparam logic [CMD_W_DEF-1:0] EXE_XOR  = 4'd5;
   localparam logic [CMD_W_DEF-1:0] EXE_SLL  = 4'd6;
   localparam logic [CMD_W_DEF-1:0] EXE_SRL  = 4'd7;
   localparam logic [CMD_W_DEF-1:0] EXE_SRA  = 4'd8;
   localparam logic [CMD_W_DEF-1:0] EXE_MULT = 4'd9;
   localparam logic [CMD_W_DEF-1:0] EXE_DIV  = 4'd10;
   localparam logic [CMD_W_DEF-1:0] EXE_MFHI = 4'd11;
   localparam logic [CMD_W_DEF-1:0] EXE_MFLO = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

   // Counter must hold 0..width-1; never narrower than one bit.
   function automatic int cnt_width(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// -----------------------------------------------------------------------------
// seq_alu_iter
//   Iterative datapath for signed MULT (shift-add) and, when SEQ_ALU_DIV_EN is
//   defined, signed DIV (restoring). Operand magnitudes and result signs are
//   latched at start; one iteration runs per cycle while run is high; the
//   sign-corrected result is presented combinationally so the top can capture
//   it on the final iteration edge.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     start           latch operands and clear the counter
//     div_sel         (SEQ_ALU_DIV_EN only) 1 = divide, 0 = multiply
//     run             perform one iteration this edge
//     val1, val2      operands (multiplicand / dividend, multiplier / divisor)
//     last            counter is at WIDTH-1 (final iteration this edge)
//     hi_res, lo_res  result after the current iteration, signs fixed up
// -----------------------------------------------------------------------------
module seq_alu_iter
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef SEQ_ALU_DIV_EN
   input  logic             div_sel,
`endif
   input  logic             run,
   input  logic [WIDTH-1:0] val1,
   input  logic [WIDTH-1:0] val2,
   output logic             last,
   output logic [WIDTH-1:0] hi_res,
   output logic [WIDTH-1:0] lo_res
);

   localparam int                CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0]     cnt;
   logic [WIDTH-1:0]     mag_b;     // multiplicand (MULT) or divisor (DIV) magnitude
   logic [2*WIDTH-1:0]   acc;       // {upper, lower}: {partial product, multiplier} or {remainder, quotient}
   logic                 neg_sign;  // product / quotient must be negated
   logic [WIDTH-1:0]     mag1;
   logic [WIDTH-1:0]     mag2;
   logic [WIDTH-1:0]     addend;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [2*WIDTH-1:0]   product;
   logic [2*WIDTH-1:0]   acc_next;
`ifdef SEQ_ALU_DIV_EN
   logic                 div_mode;
   logic                 div_zero;
   logic                 neg_rem;   // remainder takes the dividend's sign
   logic [WIDTH-1:0]     r_sh;
   logic [WIDTH:0]       diff;
   logic [2*WIDTH-1:0]   div_next;
   logic [WIDTH-1:0]     quo;
   logic [WIDTH-1:0]     rem;
`endif

   // Magnitude of the most-negative value is 2^(WIDTH-1), still representable unsigned.
   assign mag1 = val1[WIDTH-1] ? -val1 : val1;
   assign mag2 = val2[WIDTH-1] ? -val2 : val2;

   assign last = (cnt == CNT_LAST);

   // Shift-add step: add the multiplicand when the multiplier LSB is set,
   // then shift the whole {carry, upper, lower} right by one.
   assign addend   = acc[0] ? mag_b : {WIDTH{1'b0}};
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};
   assign product  = neg_sign ? -mul_next : mul_next;

`ifdef SEQ_ALU_DIV_EN
   // Restoring step: shift {rem, quo} left, trial-subtract the divisor, keep
   // the difference and shift in a 1 when it does not borrow. The remainder
   // stays below 2^(WIDTH-1), so dropping its top bit on the shift is safe.
   assign r_sh     = {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]};
   assign diff     = {1'b0, r_sh} - {1'b0, mag_b};
   assign div_next = {(diff[WIDTH] ? r_sh : diff[WIDTH-1:0]), acc[WIDTH-2:0], ~diff[WIDTH]};
`endif

   // NOTE: every output of this block is given a default first, so no path
   // through it can leave a value held and infer a latch.
   always_comb begin
      acc_next = mul_next;
      hi_res   = product[2*WIDTH-1:WIDTH];
      lo_res   = product[WIDTH-1:0];
`ifdef SEQ_ALU_DIV_EN
      quo = div_next[WIDTH-1:0];
      rem = div_next[2*WIDTH-1:WIDTH];
      if (div_mode) begin
         acc_next = div_next;
         // A zero divisor leaves rem = |val1|, so the sign fix-up restores val1.
         lo_res   = div_zero ? {WIDTH{1'b1}} : (neg_sign ? -quo : quo);
         hi_res   = neg_rem ? -rem : rem;
      end
`endif
   end

   // NOTE: registered state uses non-blocking assignments only, so every
   // flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         acc      <= '0;
         mag_b    <= '0;
         neg_sign <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
         div_mode <= 1'b0;
         div_zero <= 1'b0;
         neg_rem  <= 1'b0;
`endif
      end else if (start) begin
         cnt      <= '0;
         neg_sign <= val1[WIDTH-1] ^ val2[WIDTH-1];
`ifdef SEQ_ALU_DIV_EN
         div_mode <= div_sel;
         div_zero <= (val2 == '0);
         neg_rem  <= val1[WIDTH-1];
         if (div_sel) begin
            mag_b <= mag2;
            acc   <= {{WIDTH{1'b0}}, mag1};
         end else begin
            mag_b <= mag1;
            acc   <= {{WIDTH{1'b0}}, mag2};
         end
`else
         mag_b    <= mag1;
         acc      <= {{WIDTH{1'b0}}, mag2};
`endif
      end else if (run) begin
         cnt <= cnt + 1'b1;
         acc <= acc_next;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Multi-cycle execute-stage ALU. Single-cycle ops (ADD, SUB, AND, OR, NOR,
//   XOR, SLL, SRL, SRA, MFHI, MFLO, unknown codes) return a registered result
//   one edge after acceptance. MULT (and DIV with SEQ_ALU_DIV_EN defined) take
//   WIDTH edges in seq_alu_iter and write HI/LO. in_ready is low while busy.
//   Optional feature macro: SEQ_ALU_DIV_EN (signed restoring divide, code 10).
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     in_valid, in_ready  operation handshake (accept on in_valid && in_ready)
//     exe_cmd             operation code
//     val1, val2, shamt   operands and shift amount
//     out_valid           one-cycle pulse with alu_out valid
//     alu_out             result
//     hi, lo              architectural HI/LO registers
// -----------------------------------------------------------------------------
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int CMD_W   = 4,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CMD_W-1:0]   exe_cmd,
   input  logic [WIDTH-1:0]   val1,
   input  logic [WIDTH-1:0]   val2,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   output logic [WIDTH-1:0]   alu_out,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);

   state_t           state;
   logic             accept;
   logic             is_mult;
   logic             iter_start;
   logic             iter_run;
   logic             iter_last;
   logic [WIDTH-1:0] iter_hi;
   logic [WIDTH-1:0] iter_lo;
   logic [WIDTH-1:0] sc_result;
`ifdef SEQ_ALU_DIV_EN
   logic             is_div;
`endif

   assign in_ready = (state == ST_IDLE);
   assign accept   = in_valid && in_ready;
   assign is_mult  = (exe_cmd == CMD_W'(EXE_MULT));
   assign iter_run = (state != ST_IDLE);

`ifdef SEQ_ALU_DIV_EN
   assign is_div     = (exe_cmd == CMD_W'(EXE_DIV));
   assign iter_start = accept && (is_mult || is_div);
`else
   assign iter_start = accept && is_mult;
`endif

   seq_alu_iter #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (iter_start),
`ifdef SEQ_ALU_DIV_EN
      .div_sel(is_div),
`endif
      .run    (iter_run),
      .val1   (val1),
      .val2   (val2),
      .last   (iter_last),
      .hi_res (iter_hi),
      .lo_res (iter_lo)
   );

   // Single-cycle result; unknown codes (and code 10 without the divider) give 0.
   always_comb begin
      sc_result = '0;
      case (exe_cmd)
         CMD_W'(EXE_ADD):  sc_result = val1 + val2;
         CMD_W'(EXE_SUB):  sc_result = val1 - val2;
         CMD_W'(EXE_AND):  sc_result = val1 & val2;
         CMD_W'(EXE_OR):   sc_result = val1 | val2;
         CMD_W'(EXE_NOR):  sc_result = ~(val1 | val2);
         CMD_W'(EXE_XOR):  sc_result = val1 ^ val2;
         CMD_W'(EXE_SLL):  sc_result = val1 << shamt;
         CMD_W'(EXE_SRL):  sc_result = val1 >> shamt;
         CMD_W'(EXE_SRA):  sc_result = $signed(val1) >>> shamt;
         CMD_W'(EXE_MFHI): sc_result = hi;
         CMD_W'(EXE_MFLO): sc_result = lo;
         default:          sc_result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         alu_out   <= '0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (is_mult) begin
                     state <= ST_MUL;
`ifdef SEQ_ALU_DIV_EN
                  end else if (is_div) begin
                     state <= ST_DIV;
`endif
                  end else begin
                     alu_out   <= sc_result;
                     out_valid <= 1'b1;
                  end
               end
            end
`ifdef SEQ_ALU_DIV_EN
            ST_MUL, ST_DIV: begin
`else
            ST_MUL: begin
`endif
               // Final iteration edge: capture the fixed-up result.
               if (iter_last) begin
                  hi        <= iter_hi;
                  lo        <= iter_lo;
                  alu_out   <= iter_lo;
                  out_valid <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
